// File: rtl/read_response_router.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : read_response_router
// Purpose  : Routes R-channel bursts from the memory-side slave back to the
//            master port that issued them. The first beat of each burst is
//            looked up in the Mapper by ID. Later beats reuse the same port.
// Revision : 1.0 - initial release
// ============================================================================
module read_response_router #(
    parameter  int ID_WIDTH        = 6,
    parameter  int NUMBER_OF_PORTS = 2,
    parameter  int DATA_WIDTH      = 128,
    localparam int PORT_WIDTH      = (NUMBER_OF_PORTS > 1) ? $clog2(NUMBER_OF_PORTS) : 1
) (
    input  logic                       clock,
    input  logic                       reset,            // active-low, asynchronous
    // slave-side R channel
    input  logic [ID_WIDTH:0]          s_rid,
    input  logic [DATA_WIDTH-1:0]      s_rdata,
    input  logic [1:0]                 s_rresp,
    input  logic                       s_rlast,
    input  logic                       s_rvalid,
    output logic                       s_rready,
    // Mapper lookup port
    output logic [ID_WIDTH:0]          read_look_after,
    input  logic [PORT_WIDTH-1:0]      read_came_from,
    // master-side R channels (payload broadcast, valid one-hot)
    output logic [ID_WIDTH:0]          m_rid,
    output logic [DATA_WIDTH-1:0]      m_rdata,
    output logic [1:0]                 m_rresp,
    output logic                       m_rlast,
    output logic [NUMBER_OF_PORTS-1:0] m_rvalid,
    input  logic [NUMBER_OF_PORTS-1:0] m_rready,
    output logic                       error
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_SEND   = 3'd2,
        ST_BURST  = 3'd3,
        ST_DROP   = 3'd4
    } state_t;

    state_t                  state_q,    state_d;
    logic [ID_WIDTH:0]       id_q,       id_d;
    logic [DATA_WIDTH-1:0]   data_q,     data_d;
    logic [1:0]              resp_q,     resp_d;
    logic                    last_q,     last_d;
    logic [ID_WIDTH:0]       look_q,     look_d;
    logic [PORT_WIDTH-1:0]   port_sel_q, port_sel_d;
    logic                    error_q,    error_d;

    logic                    accept;
    logic                    sel_ready;
    logic                    port_ok;

    // Ready is decoded from the state. Gating it with reset keeps it low
    // while reset is held, even though the state already reads IDLE then.
    assign s_rready = reset && ((state_q == ST_IDLE) ||
                                (state_q == ST_BURST) ||
                                (state_q == ST_DROP));
    assign accept   = s_rvalid && s_rready;

    // Mapper results outside the port range are treated as routing errors.
    assign port_ok  = (int'(read_came_from) < NUMBER_OF_PORTS);

    // Select the ready of the currently routed port; other ports are ignored.
    always_comb begin
        sel_ready = 1'b0;
        for (int p = 0; p < NUMBER_OF_PORTS; p++) begin
            if (port_sel_q == PORT_WIDTH'(p)) begin
                sel_ready = m_rready[p];
            end
        end
    end

    // Next-state and payload-capture logic for the burst serialiser.
    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        data_d     = data_q;
        resp_d     = resp_q;
        last_d     = last_q;
        look_d     = look_q;
        port_sel_d = port_sel_q;
        error_d    = error_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    id_d    = s_rid;
                    data_d  = s_rdata;
                    resp_d  = s_rresp;
                    last_d  = s_rlast;
                    look_d  = s_rid;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                port_sel_d = read_came_from;
                if (!port_ok) begin
                    error_d = 1'b1;
                    state_d = last_q ? ST_IDLE : ST_DROP;
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (sel_ready) begin
                    state_d = last_q ? ST_IDLE : ST_BURST;
                end
            end
            ST_BURST: begin
                if (accept) begin
                    id_d   = s_rid;
                    data_d = s_rdata;
                    resp_d = s_rresp;
                    last_d = s_rlast;
                    // A beat whose ID differs from the burst's first ID is
                    // still forwarded, but the error is flagged.
                    if (s_rid != look_q) begin
                        error_d = 1'b1;
                    end
                    state_d = ST_SEND;
                end
            end
            ST_DROP: begin
                if (accept && s_rlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and payload registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            id_q       <= '0;
            data_q     <= '0;
            resp_q     <= '0;
            last_q     <= 1'b0;
            look_q     <= '0;
            port_sel_q <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            data_q     <= data_d;
            resp_q     <= resp_d;
            last_q     <= last_d;
            look_q     <= look_d;
            port_sel_q <= port_sel_d;
            error_q    <= error_d;
        end
    end

    // One-hot valid decoded purely from registered state and port select.
    always_comb begin
        m_rvalid = '0;
        for (int p = 0; p < NUMBER_OF_PORTS; p++) begin
            m_rvalid[p] = (state_q == ST_SEND) && (port_sel_q == PORT_WIDTH'(p));
        end
    end

    assign m_rid           = id_q;
    assign m_rdata         = data_q;
    assign m_rresp         = resp_q;
    assign m_rlast         = last_q;
    assign read_look_after = look_q;
    assign error           = error_q;

endmodule
`default_nettype wire

// File: tb/tb_read_response_router.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_read_response_router
// Purpose  : Scoreboard bench for read_response_router (3-port build so that
//            an out-of-range Mapper result can be produced).
// Revision : 1.0 - initial release
// ============================================================================
module tb_read_response_router;

    localparam int IDW = 6;
    localparam int NP  = 3;
    localparam int DW  = 128;
    localparam int PW  = 2;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [IDW:0]    s_rid = '0;
    logic [DW-1:0]   s_rdata = '0;
    logic [1:0]      s_rresp = '0;
    logic            s_rlast = 1'b0;
    logic            s_rvalid = 1'b0;
    logic            s_rready;
    logic [IDW:0]    read_look_after;
    logic [PW-1:0]   read_came_from;
    logic [IDW:0]    m_rid;
    logic [DW-1:0]   m_rdata;
    logic [1:0]      m_rresp;
    logic            m_rlast;
    logic [NP-1:0]   m_rvalid;
    logic [NP-1:0]   m_rready = '0;
    logic            error;

    read_response_router #(
        .ID_WIDTH        (IDW),
        .NUMBER_OF_PORTS (NP),
        .DATA_WIDTH      (DW)
    ) u_dut (
        .clock           (clock),
        .reset           (reset),
        .s_rid           (s_rid),
        .s_rdata         (s_rdata),
        .s_rresp         (s_rresp),
        .s_rlast         (s_rlast),
        .s_rvalid        (s_rvalid),
        .s_rready        (s_rready),
        .read_look_after (read_look_after),
        .read_came_from  (read_came_from),
        .m_rid           (m_rid),
        .m_rdata         (m_rdata),
        .m_rresp         (m_rresp),
        .m_rlast         (m_rlast),
        .m_rvalid        (m_rvalid),
        .m_rready        (m_rready),
        .error           (error)
    );

    always #5 clock = ~clock;

    // Mapper model: ID -> master port; value NP or above is out of range.
    logic [PW-1:0] map [0:127];
    assign read_came_from = map[read_look_after];

    typedef struct packed {
        logic [PW-1:0] port;
        logic [IDW:0]  id;
        logic [1:0]    resp;
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    beat_t         exp_q[$];
    int            n_cmp = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            lookups = 0;
    int            delivered = 0;
    int            last_hs_cyc = 0;
    bit            exp_err = 1'b0;
    bit            rdy_rand = 1'b0;
    logic [NP-1:0] rdy_fix = '1;

    function automatic void check(string name, logic [255:0] act, logic [255:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // Master-side ready: fixed pattern for directed tests, random otherwise.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            m_rready = rdy_rand ? NP'($urandom) : rdy_fix;
        end
    end

    // Monitor: pops the scoreboard on every master-side handshake.
    always @(negedge clock) begin
        beat_t got;
        beat_t e;
        if (reset) begin
            if (!s_rready && (m_rvalid == '0)) lookups++;
            if (m_rvalid != '0) begin
                check("valid_onehot", 256'($countones(m_rvalid)), 256'(1));
                for (int p = 0; p < NP; p++) begin
                    if (m_rvalid[p] && m_rready[p]) begin
                        got.port = PW'(p);
                        got.id   = m_rid;
                        got.resp = m_rresp;
                        got.last = m_rlast;
                        got.data = m_rdata;
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_fail++;
                            $display("FAIL unexpected_beat: got %0h, required none", got);
                        end else begin
                            e = exp_q.pop_front();
                            check("beat", 256'(got), 256'(e));
                        end
                        delivered++;
                        last_hs_cyc = cyc + 1;
                    end
                end
            end
        end
    end

    // Offer one beat, driven at a negedge where s_rready is already high.
    task automatic drive_beat(input logic [IDW:0] id, input logic [DW-1:0] d,
                              input logic [1:0] r, input logic l, output int acc);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (s_rready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: got s_rready=0, required 1");
            acc = cyc;
            return;
        end
        s_rid    = id;
        s_rdata  = d;
        s_rresp  = r;
        s_rlast  = l;
        s_rvalid = 1'b1;
        @(posedge clock);
        #1;
        acc      = cyc;
        s_rvalid = 1'b0;
    endtask

    // Issue a burst and push the expected delivered beats into the scoreboard.
    task automatic send_burst(input logic [IDW:0] first_id, input int len,
                              input logic [DW-1:0] d0, input int alt_beat,
                              input logic [IDW:0] alt_id, input int mm_pct,
                              output int first_acc);
        logic [PW-1:0] port;
        bit            bad;
        beat_t         b;
        int            acc;
        port = map[first_id];
        bad  = (int'(port) >= NP);
        if (bad) exp_err = 1'b1;
        for (int i = 0; i < len; i++) begin
            b.port = port;
            b.id   = first_id;
            if (i == alt_beat) b.id = alt_id;
            else if (i > 0 && $urandom_range(0, 99) < mm_pct) b.id = IDW'($urandom);
            b.resp = 2'($urandom);
            b.last = (i == len - 1);
            b.data = d0 + DW'(i);
            if (!bad) begin
                exp_q.push_back(b);
                if (b.id != first_id) exp_err = 1'b1;
            end
            drive_beat(b.id, b.data, b.resp, b.last, acc);
            if (i == 0) first_acc = acc;
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 1000; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clock);
        end
        check("drain", 256'(exp_q.size()), 256'(0));
        repeat (3) @(posedge clock);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        exp_q.delete();
        exp_err = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fa;
        int l0;
        int d0;
        logic [DW-1:0] bp_data;

        for (int i = 0; i < 128; i++) map[i] = PW'($urandom_range(0, NP - 1));
        map[7'h21] = 2'd1;
        map[7'h20] = 2'd0;
        map[7'h05] = 2'd3;

        // Reset state while reset is held low.
        #12;
        check("rst_s_rready", 256'(s_rready), 256'(0));
        check("rst_m_rvalid", 256'(m_rvalid), 256'(0));
        check("rst_error", 256'(error), 256'(0));
        check("rst_look", 256'(read_look_after), 256'(0));
        check("rst_payload", 256'({m_rid, m_rresp, m_rlast, m_rdata}), 256'(0));
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("idle_s_rready", 256'(s_rready), 256'(1));

        // Single beat, latency T+2 on port 1.
        send_burst(7'h21, 1, DW'(8'hA5), -1, '0, 0, fa);
        @(negedge clock);
        check("lookup_valid", 256'(m_rvalid), 256'(0));
        check("lookup_s_rready", 256'(s_rready), 256'(0));
        check("lookup_id", 256'(read_look_after), 256'(7'h21));
        @(negedge clock);
        check("t2_valid", 256'(m_rvalid), 256'(3'b010));
        check("t2_data", 256'(m_rdata), 256'(8'hA5));
        check("t2_id", 256'(m_rid), 256'(7'h21));
        @(negedge clock);
        check("post_hs_s_rready", 256'(s_rready), 256'(1));
        check("post_hs_valid", 256'(m_rvalid), 256'(0));
        wait_drain();
        check("look_held", 256'(read_look_after), 256'(7'h21));

        // Four-beat burst on port 0: one lookup, 8 cycles to last handshake.
        l0 = lookups;
        send_burst(7'h20, 4, DW'(1), -1, '0, 0, fa);
        wait_drain();
        check("burst_lookups", 256'(lookups - l0), 256'(1));
        check("burst_cycles", 256'(last_hs_cyc - fa), 256'(8));

        // Back-pressure on port 1 for 5 cycles while port 0 is ready.
        rdy_fix = 3'b001;
        repeat (2) @(posedge clock);
        bp_data = {$urandom, $urandom, $urandom, $urandom};
        send_burst(7'h21, 1, bp_data, -1, '0, 0, fa);
        @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("bp_valid", 256'(m_rvalid), 256'(3'b010));
            check("bp_data", 256'(m_rdata), 256'(bp_data));
            check("bp_s_rready", 256'(s_rready), 256'(0));
        end
        rdy_fix = 3'b011;
        @(negedge clock);
        check("bp_hs_valid", 256'(m_rvalid), 256'(3'b010));
        @(negedge clock);
        check("bp_after_valid", 256'(m_rvalid), 256'(0));
        check("bp_after_s_rready", 256'(s_rready), 256'(1));
        rdy_fix = '1;
        wait_drain();

        // ID mismatch inside a burst: flagged, still delivered on port 1.
        check("pre_mm_error", 256'(error), 256'(0));
        send_burst(7'h21, 3, DW'(16'h1000), 1, 7'h20, 0, fa);
        wait_drain();
        check("mm_error", 256'(error), 256'(1));
        send_burst(7'h20, 2, DW'(16'h2000), -1, '0, 0, fa);
        wait_drain();
        check("mm_error_sticky", 256'(error), 256'(1));

        // Out-of-range Mapper result: burst consumed silently, then recovery.
        apply_reset();
        check("rst_clears_error", 256'(error), 256'(0));
        d0 = delivered;
        send_burst(7'h05, 2, DW'(16'h3000), -1, '0, 0, fa);
        send_burst(7'h05, 1, DW'(16'h3100), -1, '0, 0, fa);
        repeat (5) @(posedge clock);
        check("drop_error", 256'(error), 256'(1));
        check("drop_none_delivered", 256'(delivered - d0), 256'(0));
        send_burst(7'h20, 1, DW'(16'h4000), -1, '0, 0, fa);
        wait_drain();
        check("drop_recover", 256'(delivered - d0), 256'(1));

        // Reset asserted while beat 2 of 4 sits in SEND.
        apply_reset();
        exp_q.push_back('{port: 2'd0, id: 7'h20, resp: 2'd0, last: 1'b0, data: DW'(16'h5001)});
        drive_beat(7'h20, DW'(16'h5001), 2'd0, 1'b0, fa);
        drive_beat(7'h21, DW'(16'h5002), 2'd0, 1'b0, fa);
        check("mid_send_valid", 256'(m_rvalid), 256'(3'b001));
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_valid", 256'(m_rvalid), 256'(0));
        check("async_rst_s_rready", 256'(s_rready), 256'(0));
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("mid_rst_s_rready", 256'(s_rready), 256'(1));
        check("mid_rst_error", 256'(error), 256'(0));
        check("mid_rst_valid", 256'(m_rvalid), 256'(0));
        check("mid_rst_queue", 256'(exp_q.size()), 256'(0));

        // Randomised traffic against the burst-level reference model.
        apply_reset();
        for (int i = 0; i < 128; i++)
            map[i] = ($urandom_range(0, 4) == 0) ? 2'd3 : PW'($urandom_range(0, NP - 1));
        rdy_rand = 1'b1;
        for (int n = 0; n < 150; n++) begin
            repeat ($urandom_range(0, 2)) @(posedge clock);
            send_burst(IDW'($urandom), $urandom_range(1, 4),
                       {$urandom, $urandom, $urandom, $urandom}, -1, '0, 8, fa);
        end
        wait_drain();
        check("rand_error", 256'(error), 256'(exp_err));
        rdy_rand = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/read_response_router.md
Name: read_response_router

Overview:
- Sits directly downstream of the Mapper on the read-response path.
- Accepts R-channel beats from the single memory-side slave and queries the Mapper's read lookup port with each burst's transaction ID.
- Steers every beat of the burst back to the originating master port returned by the Mapper.
- Serialises bursts: one ID lookup per burst, then the remaining beats follow on the same port without another lookup.

Parameters:
- ID_WIDTH, 6, MSB index of the transaction ID; IDs are ID_WIDTH+1 bits wide, matching the Mapper.
- NUMBER_OF_PORTS, 2, number of master-side ports; PORT_WIDTH = max(1, $clog2(NUMBER_OF_PORTS)).
- DATA_WIDTH, 128, R-channel data width.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; the port name stays "reset" even though it is active-low.
- s_rid  input  ID_WIDTH+1  ID of the incoming beat.
- s_rdata  input  DATA_WIDTH  beat data.
- s_rresp  input  2  beat response.
- s_rlast  input  1  last beat of the burst.
- s_rvalid  input  1  incoming beat valid.
- s_rready  output  1  router can accept a beat.
- read_look_after  output  ID_WIDTH+1  ID presented to the Mapper lookup.
- read_came_from  input  PORT_WIDTH  Mapper result, valid one cycle after read_look_after changes.
- m_rid  output  ID_WIDTH+1  beat ID, broadcast to all master ports.
- m_rdata  output  DATA_WIDTH  beat data, broadcast.
- m_rresp  output  2  beat response, broadcast.
- m_rlast  output  1  beat last flag, broadcast.
- m_rvalid  output  NUMBER_OF_PORTS  one-hot valid; only the selected port's bit is set.
- m_rready  input  NUMBER_OF_PORTS  per-port ready.
- error  output  1  sticky error flag, cleared only by reset.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - s_rready=0 while reset is asserted.
  - m_rvalid=0, error=0.
  - Payload registers, read_look_after and port_sel all 0.
  - After reset deasserts: s_rready=1 in IDLE.
- IDLE:
  - s_rready=1.
  - On s_rvalid&s_rready: capture id/data/resp/last into the beat register, drive read_look_after=captured id, go LOOKUP.
- LOOKUP (exactly 1 cycle):
  - s_rready=0.
  - At the clock edge, register read_came_from into port_sel.
  - If read_came_from >= NUMBER_OF_PORTS: set error and discard the beat. If the discarded beat has last=1, go IDLE; otherwise go DROP.
  - Else go SEND.
- SEND:
  - m_rvalid[port_sel]=1; all other m_rvalid bits are 0.
  - m_r* carry the beat register.
  - Hold the beat until m_rready[port_sel]=1; ready bits of other ports are ignored.
  - On handshake: if last=1, go IDLE; else go BURST.
- BURST:
  - s_rready=1, m_rvalid=0.
  - On accept: capture the beat, go SEND with the same port_sel; no new lookup.
  - If s_rid differs from the burst's first ID: set error and still route the beat to port_sel.
- DROP:
  - s_rready=1.
  - Consume and discard beats until s_rlast=1 is accepted, then go IDLE.
- read_look_after holds the last looked-up ID until the next IDLE capture.
- Latency and throughput:
  - First beat accepted at cycle T: m_rvalid asserts at T+2.
  - Subsequent burst beats: 2 cycles per beat (accept, send) when m_rready is held high.
- Ordering: beats leave in the order received, never reordered.
- Output stability: no combinational path from s_r* or read_came_from to m_r*; all m_r* outputs are registered.
- Back-pressure: m_rready low indefinitely means SEND is held and s_rready stays 0; the payload must not change while held.
- Reset mid-burst: the FSM returns to IDLE, and the partially forwarded burst is abandoned without further m_rvalid.

Test Plan:
- Mapper entries {0x21->1, 0x20->0}; single beat id=0x21, last=1, data=0xA5 -> m_rvalid=2'b10 at T+2 with m_rdata=0xA5, m_rid=0x21; s_rready back to 1 one cycle after the handshake.
- 4-beat burst id=0x20, data 1..4, m_rready[0]=1 -> exactly one lookup; m_rvalid=2'b01 for beats 1,2,3,4 in order; m_rlast only on beat 4; 8 cycles total from the first accept.
- Back-pressure: single beat to port 1, m_rready[1] low for 5 cycles while m_rready[0]=1 -> m_rvalid stays 2'b10 with stable payload; s_rready=0 throughout; handshake on the cycle m_rready[1] rises.
- Burst where beat 2 carries id=0x20 after first beat id=0x21 -> error=1 (sticky); beat 2 is still delivered on port 1.
- NUMBER_OF_PORTS=3 with Mapper returning 3 for a 2-beat burst -> no m_rvalid; both beats consumed; error=1; next burst routed normally.
- Assert reset=0 during SEND of beat 2 of 4 -> m_rvalid=0 and s_rready=0 immediately (asynchronously); after release, state is IDLE with s_rready=1 and error=0.
